truth_table_probe: RTL and testbench
====================================

# truth_table_probe

Sequential prober that drives all eight input combinations into a 3-input, 1-output combinational lab circuit (ports `l`, `s`, `q` in, `m` out) and captures the response into an 8-bit truth table. It then compares the table against an expected table. It sits on the driving and observing side of the circuit under test, so a lab bench or FPGA wrapper can characterise a black-box gate network without manual toggling.

## Interface
- `SETTLE`, default 1: extra hold cycles per vector before sampling; legal range 0..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; returns block to IDLE.
- `start` input 1: one-cycle (or level) request to begin a sweep; honoured only in IDLE or DONE.
- `expected` input 8: reference truth table; bit i is the expected `m` for vector i; latched on accepted `start`.
- `m` input 1: output of circuit under test.
- `l` output 1: drive to circuit; bit 2 of current vector index.
- `s` output 1: drive to circuit; bit 1 of current vector index.
- `q` output 1: drive to circuit; bit 0 of current vector index.
- `busy` output 1: high while sweeping (DRIVE state).
- `done` output 1: high in DONE state; table and compare results are valid.
- `table` output 8: captured responses; bit i = `m` sampled for vector i.
- `mismatch` output 8: `table ^ expected_latched`; meaningful only while `done`.
- `pass` output 1: `done & (mismatch == 0)`.

## Operation
- States: IDLE, DRIVE, DONE. All outputs are registered, or are pure functions of registers.
- Internal registers: `idx` (3 bits), `cnt` (4 bits), `table` (8 bits), `exp_q` (8 bits), and the state register.
- The vector driven is `{l,s,q} = idx` (`l` is the MSB).
- IDLE: `idx=0`, `cnt=0`, `busy=0`, `done=0`.
  - If `start` is high: clear `table` to 0, latch `expected` into `exp_q`, set `idx=0` and `cnt=0`, go to DRIVE.
- DRIVE: `busy=1`.
  - Each edge with `cnt != SETTLE`: `cnt <= cnt+1`.
  - Each edge with `cnt == SETTLE`: `table[idx] <= m` and `cnt <= 0`.
    - If `idx==7`, go to DONE with `idx <= 0`.
    - Otherwise `idx <= idx+1`.
- Each vector is held for exactly SETTLE+1 cycles. `m` is sampled on the edge that ends the final hold cycle.
- DONE: `done=1`, `{l,s,q}=000`, and `table`/`exp_q` are held.
  - If `start` is high: behave exactly as a `start` in IDLE (clear, latch, go to DRIVE).
- `start` during DRIVE is ignored, and `expected` changes during DRIVE are ignored.
- `idx` wraps 7→0 only via the DONE transition. No sweep ever samples a vector twice.
- Index order is fixed at 0..7. Bit i of `table` always corresponds to `{l,s,q}=i`.

## Timing
- Reset (synchronous): on the edge with `reset=1`, go to IDLE and zero all registers.
  - After that edge: `l=s=q=0`, `busy=0`, `done=0`, `table=0`, `mismatch=0`, `pass=0`.
  - `reset` takes priority over `start` on the same edge.
- Reset mid-sweep: the sweep is abandoned, the partial table is cleared, and nothing is reported as done.
- `start` sampled at edge E0:
  - After E0, `busy=1` and vector 0 is driven.
  - Vector i is sampled at edge E0+(i+1)(SETTLE+1).
  - After edge E0+8(SETTLE+1), `done=1` and `busy=0`.
  - Total sweep latency is 8(SETTLE+1) cycles; this is 16 cycles for the default.
- `busy` and `done` are never high simultaneously.
- With SETTLE=0, vectors change every cycle and `m` is sampled on the edge ending the single cycle the vector is driven.
- Restart from DONE: on the edge sampling `start`, `done` falls and `busy` rises. `table` reads 0 from the next cycle.

## Test plan
- NAND device: `m = ~(l&s&q)`, SETTLE=1, `expected=8'h7F`, pulse `start`.
  - Required: `done` rises exactly 16 cycles after the start edge, with `table=8'h7F`, `mismatch=8'h00`, `pass=1`.
- Wrong expectation: same NAND device, `expected=8'hFF`.
  - Required: `table=8'h7F`, `mismatch=8'h80`, `pass=0`.
- Vector and timing check: SETTLE=0, device `m = l`.
  - Required: `{l,s,q}` steps 0,1,...,7 one per cycle, `table=8'hF0`, and `done` is high 8 cycles after start.
- Reset mid-sweep: assert `reset` on cycle 5 of a SETTLE=1 sweep.
  - Required: next cycle `busy=0`, `done=0`, `table=0`, `l=s=q=0`.
  - A later `start` then produces a full correct sweep.
- Start during sweep: pulse `start` again at cycle 3 and change `expected` meanwhile.
  - Required: no restart, `done` at cycle 16, and compare uses the originally latched `expected`.
- Restart from DONE: after a completed sweep, pulse `start` with device now `m = q` (`expected=8'hAA`).
  - Required: `table` clears, then reads `8'hAA` with `pass=1` 16 cycles later.
- Reset/start collision: `reset` and `start` asserted on the same edge.
  - Required: block stays in IDLE.

Source files
------------

// File: rtl/truth_table_probe.sv
// truth_table_probe: sweeps the eight {l,s,q} vectors into a 3-in/1-out circuit,
// captures m for each vector into an 8-bit table and compares it with a
// reference table latched at start.
module truth_table_probe #(
   parameter int unsigned SETTLE = 1   // extra hold cycles per vector, 0..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       m,
   output logic       l,
   output logic       s,
   output logic       q,
   output logic       busy,
   output logic       done,
   output logic [7:0] tbl,
   output logic [7:0] mismatch,
   output logic       pass
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] table_q, table_d;
   logic [7:0] exp_q, exp_d;

   // State register and datapath flops; reset zeroes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         exp_q   <= exp_d;
      end
   end

   // Next-state: start is accepted only when not sweeping; each vector is held
   // SETTLE+1 cycles and m is captured on the edge closing the last hold cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      exp_d   = exp_q;
      unique case (state_q)
         IDLE, DONE: begin
            idx_d = '0;
            cnt_d = '0;
            if (start) begin
               table_d = '0;
               exp_d   = expected;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q != SETTLE_C) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               table_d[idx_q] = m;
               cnt_d          = '0;
               if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registers or pure functions of registers; idx is 0 outside
   // DRIVE so the circuit sees 000 when idle or done.
   always_comb begin
      {l, s, q} = idx_q;
      busy      = (state_q == DRIVE);
      done      = (state_q == DONE);
      tbl       = table_q;
      mismatch  = table_q ^ exp_q;
      pass      = done & (mismatch == 8'h00);
   end

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench: SETTLE=1 probe on a NAND / q device, SETTLE=0 probe on an m=l device.
module tb_truth_table_probe;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start1 = 1'b0, start0 = 1'b0;
   logic [7:0] exp1 = 8'h00, exp0 = 8'h00;
   logic       dev1 = 1'b0;   // 0: NAND, 1: m = q
   logic       m1, m0;
   logic       l1, s1, q1, busy1, done1, pass1;
   logic       l0, s0, q0, busy0, done0, pass0;
   logic [7:0] tbl1, mis1, tbl0, mis0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Lab devices under probe.
   always_comb begin
      m1 = dev1 ? q1 : ~(l1 & s1 & q1);
      m0 = l0;
   end

   truth_table_probe #(.SETTLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .expected(exp1), .m(m1),
      .l(l1), .s(s1), .q(q1), .busy(busy1), .done(done1),
      .tbl(tbl1), .mismatch(mis1), .pass(pass1));

   truth_table_probe #(.SETTLE(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .expected(exp0), .m(m0),
      .l(l0), .s(s0), .q(q0), .busy(busy0), .done(done0),
      .tbl(tbl0), .mismatch(mis0), .pass(pass0));

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Pulse start1 for one edge (E0); returns 1 ns after E0.
   task automatic go1(input logic [7:0] e);
      exp1   = e;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_busy", {7'd0, busy1}, 8'h00);
      chk("rst_done", {7'd0, done1}, 8'h00);
      chk("rst_tbl", tbl1, 8'h00);
      chk("rst_mis", mis1, 8'h00);
      chk("rst_pass", {7'd0, pass1}, 8'h00);
      chk("rst_lsq", {5'd0, l1, s1, q1}, 8'h00);

      // SETTLE=0, m = l: one vector per cycle, done 8 cycles after start
      exp0   = 8'hF0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("s0_lsq%0d", k), {5'd0, l0, s0, q0}, 8'(k));
         chk($sformatf("s0_busy%0d", k), {6'd0, busy0, done0}, 8'h02);
         tick();
      end
      chk("s0_done", {6'd0, busy0, done0}, 8'h01);
      chk("s0_tbl", tbl0, 8'hF0);
      chk("s0_pass", {7'd0, pass0}, 8'h01);

      // NAND, expected 7F
      dev1 = 1'b0;
      go1(8'h7F);
      chk("nand_start_busy", {6'd0, busy1, done1}, 8'h02);
      chk("nand_start_lsq", {5'd0, l1, s1, q1}, 8'h00);
      tick(15);
      chk("nand_pre_done", {6'd0, busy1, done1}, 8'h02);
      tick();
      chk("nand_done", {6'd0, busy1, done1}, 8'h01);
      chk("nand_tbl", tbl1, 8'h7F);
      chk("nand_mis", mis1, 8'h00);
      chk("nand_pass", {7'd0, pass1}, 8'h01);
      chk("nand_lsq", {5'd0, l1, s1, q1}, 8'h00);

      // Wrong expectation (restart from DONE)
      go1(8'hFF);
      tick(16);
      chk("wrong_done", {7'd0, done1}, 8'h01);
      chk("wrong_tbl", tbl1, 8'h7F);
      chk("wrong_mis", mis1, 8'h80);
      chk("wrong_pass", {7'd0, pass1}, 8'h00);

      // Start + expected change during sweep are ignored
      go1(8'h7F);
      tick(3);
      exp1   = 8'hFF;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick(11);
      chk("mid_pre_done", {6'd0, busy1, done1}, 8'h02);
      tick();
      chk("mid_done", {6'd0, busy1, done1}, 8'h01);
      chk("mid_mis", mis1, 8'h00);
      chk("mid_pass", {7'd0, pass1}, 8'h01);

      // Restart from DONE with m = q
      dev1 = 1'b1;
      go1(8'hAA);
      chk("rs_flags", {6'd0, busy1, done1}, 8'h02);
      chk("rs_tbl_clr", tbl1, 8'h00);
      tick(16);
      chk("rs_tbl", tbl1, 8'hAA);
      chk("rs_pass", {7'd0, pass1}, 8'h01);

      // Reset mid-sweep
      dev1 = 1'b0;
      go1(8'h7F);
      tick(4);
      chk("rm_partial", tbl1, 8'h03);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rm_flags", {6'd0, busy1, done1}, 8'h00);
      chk("rm_tbl", tbl1, 8'h00);
      chk("rm_lsq", {5'd0, l1, s1, q1}, 8'h00);
      tick(3);
      chk("rm_idle", {6'd0, busy1, done1}, 8'h00);
      go1(8'h7F);
      tick(16);
      chk("rm_re_done", {7'd0, done1}, 8'h01);
      chk("rm_re_tbl", tbl1, 8'h7F);
      chk("rm_re_pass", {7'd0, pass1}, 8'h01);

      // Reset and start on the same edge
      exp1   = 8'h55;
      reset  = 1'b1;
      start1 = 1'b1;
      tick();
      reset  = 1'b0;
      start1 = 1'b0;
      chk("col_flags", {6'd0, busy1, done1}, 8'h00);
      chk("col_mis", mis1, 8'h00);
      tick(2);
      chk("col_idle", {6'd0, busy1, done1}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
